// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back source encodings, FSM state type and
// the default register-file geometry.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } wb_state_e;
endpackage

// File: rtl/wb_mux.sv
// Write-back source select: 4:1 for the low word, 2:1 for the high word.
// The high word only exists for ALU and memory sources; other selects give 0.
module wb_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W
) (
  input  logic [1:0]        sel_i,
  input  logic [DATA_W-1:0] alu_lo_i,
  input  logic [DATA_W-1:0] alu_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] pcp4_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o
);
  always_comb begin
    lo_o = '0;
    hi_o = '0;
    case (sel_i)
      WB_ALU: begin
        lo_o = alu_lo_i;
        hi_o = alu_hi_i;
      end
      WB_MEM: begin
        lo_o = mem_lo_i;
        hi_o = mem_hi_i;
      end
      WB_PC4:  lo_o = pcp4_i;
      default: lo_o = imm_i;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registered integer/FP register-file write ports, a two-cycle
// sequence for double-word FP results (stalling upstream), and a retirement counter.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iWrite,
  input  logic              iFloat,
  input  logic [1:0]        iWBsrc,
  input  logic              iDW,
  input  logic [DATA_W-1:0] iALUout1,
  input  logic [DATA_W-1:0] iALUout2,
  input  logic [DATA_W-1:0] iMemOut1,
  input  logic [DATA_W-1:0] iMemOut2,
  input  logic [DATA_W-1:0] iPcp4,
  input  logic [DATA_W-1:0] iIm,
  input  logic [REG_AW-1:0] iDstReg,
  output logic              oIntWe,
  output logic [REG_AW-1:0] oIntAddr,
  output logic [DATA_W-1:0] oIntData,
  output logic              oFpWe,
  output logic [REG_AW-1:0] oFpAddr,
  output logic [DATA_W-1:0] oFpData,
  output logic              oStall,
  output logic [CNT_W-1:0]  oRetired,
  output logic              oDbgState
);
  wb_state_e         state_q, state_d;
  logic              int_we_q, int_we_d, fp_we_q, fp_we_d;
  logic [REG_AW-1:0] int_addr_q, int_addr_d, fp_addr_q, fp_addr_d;
  logic [DATA_W-1:0] int_data_q, int_data_d, fp_data_q, fp_data_d;
  logic [REG_AW-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [DATA_W-1:0] mux_lo, mux_hi;
  logic              dw_txn;

  wb_mux #(.DATA_W(DATA_W)) u_mux (
    .sel_i    (iWBsrc),
    .alu_lo_i (iALUout1),
    .alu_hi_i (iALUout2),
    .mem_lo_i (iMemOut1),
    .mem_hi_i (iMemOut2),
    .pcp4_i   (iPcp4),
    .imm_i    (iIm),
    .lo_o     (mux_lo),
    .hi_o     (mux_hi)
  );

  // DW only applies to FP destinations fed by a source that has a high word.
  assign dw_txn = (state_q == IDLE) && iWrite && iFloat && iDW && !iWBsrc[1];
  assign oStall = dw_txn;

  always_comb begin
    state_d     = state_q;
    int_we_d    = 1'b0;
    int_addr_d  = '0;
    int_data_d  = '0;
    fp_we_d     = 1'b0;
    fp_addr_d   = '0;
    fp_data_d   = '0;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    retired_d   = retired_q;
    case (state_q)
      IDLE: begin
        if (iWrite) begin
          retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (!iFloat) begin
            int_we_d   = |iDstReg;
            int_addr_d = iDstReg;
            int_data_d = mux_lo;
          end else begin
            fp_we_d   = 1'b1;
            fp_data_d = mux_lo;
            if (dw_txn) begin
              fp_addr_d   = {iDstReg[REG_AW-1:1], 1'b0};
              hold_addr_d = {iDstReg[REG_AW-1:1], 1'b1};
              hold_data_d = mux_hi;
              state_d     = SECOND;
            end else begin
              fp_addr_d = iDstReg;
            end
          end
        end
      end
      // Upstream still shows the stalled instruction here; ignore it.
      SECOND: begin
        fp_we_d   = 1'b1;
        fp_addr_d = hold_addr_q;
        fp_data_d = hold_data_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      int_we_q    <= 1'b0;
      int_addr_q  <= '0;
      int_data_q  <= '0;
      fp_we_q     <= 1'b0;
      fp_addr_q   <= '0;
      fp_data_q   <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      int_we_q    <= int_we_d;
      int_addr_q  <= int_addr_d;
      int_data_q  <= int_data_d;
      fp_we_q     <= fp_we_d;
      fp_addr_q   <= fp_addr_d;
      fp_data_q   <= fp_data_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      retired_q   <= retired_d;
    end
  end

  assign oIntWe    = int_we_q;
  assign oIntAddr  = int_addr_q;
  assign oIntData  = int_data_q;
  assign oFpWe     = fp_we_q;
  assign oFpAddr   = fp_addr_q;
  assign oFpData   = fp_data_q;
  assign oRetired  = retired_q;
  assign oDbgState = state_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage with a 4-bit retirement counter so wrap-around is reachable.
module tb_wb_stage;
  localparam int CW = 4;
  localparam int EW = 1 + 5 + 32 + 1 + 5 + 32 + CW + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iWrite, iFloat, iDW;
  logic [1:0]  iWBsrc;
  logic [31:0] iALUout1, iALUout2, iMemOut1, iMemOut2, iPcp4, iIm;
  logic [4:0]  iDstReg;
  logic        oIntWe, oFpWe, oStall, oDbgState;
  logic [4:0]  oIntAddr, oFpAddr;
  logic [31:0] oIntData, oFpData;
  logic [CW-1:0] oRetired;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  logic          m_second;
  logic [4:0]    m_hold_addr;
  logic [31:0]   m_hold_data;
  logic [CW-1:0] m_cnt;

  wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .iWrite(iWrite), .iFloat(iFloat), .iWBsrc(iWBsrc),
    .iDW(iDW), .iALUout1(iALUout1), .iALUout2(iALUout2), .iMemOut1(iMemOut1),
    .iMemOut2(iMemOut2), .iPcp4(iPcp4), .iIm(iIm), .iDstReg(iDstReg),
    .oIntWe(oIntWe), .oIntAddr(oIntAddr), .oIntData(oIntData), .oFpWe(oFpWe),
    .oFpAddr(oFpAddr), .oFpData(oFpData), .oStall(oStall), .oRetired(oRetired),
    .oDbgState(oDbgState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_intwe"}, 32'(oIntWe), 0);
    check({tag, "_intaddr"}, 32'(oIntAddr), 0);
    check({tag, "_intdata"}, oIntData, 0);
    check({tag, "_fpwe"}, 32'(oFpWe), 0);
    check({tag, "_fpaddr"}, 32'(oFpAddr), 0);
    check({tag, "_fpdata"}, oFpData, 0);
    check({tag, "_stall"}, 32'(oStall), 0);
    check({tag, "_retired"}, 32'(oRetired), 0);
    check({tag, "_state"}, 32'(oDbgState), 0);
  endtask

  task automatic model_reset();
    m_second    = 1'b0;
    m_hold_addr = '0;
    m_hold_data = '0;
    m_cnt       = '0;
    exp_q.delete();
  endtask

  // One cycle: drive inputs, check combinational stall, push expected
  // registered outputs, then pop and compare after the edge.
  task automatic step(input string tag, input logic wr, input logic flt, input logic dw,
                      input logic [1:0] src, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] m1, input logic [31:0] m2, input logic [31:0] pc,
                      input logic [31:0] im, input logic [4:0] dst);
    logic [31:0] lo, hi, e_intdata, e_fpdata;
    logic [4:0]  e_intaddr, e_fpaddr;
    logic        e_intwe, e_fpwe, e_stall, e_state;
    logic [EW-1:0] got;
    iWrite = wr; iFloat = flt; iDW = dw; iWBsrc = src;
    iALUout1 = a1; iALUout2 = a2; iMemOut1 = m1; iMemOut2 = m2;
    iPcp4 = pc; iIm = im; iDstReg = dst;
    case (src)
      2'd0: begin lo = a1; hi = a2; end
      2'd1: begin lo = m1; hi = m2; end
      2'd2: begin lo = pc; hi = 0; end
      default: begin lo = im; hi = 0; end
    endcase
    e_intwe = 0; e_intaddr = 0; e_intdata = 0;
    e_fpwe = 0; e_fpaddr = 0; e_fpdata = 0; e_stall = 0;
    if (m_second) begin
      e_fpwe = 1; e_fpaddr = m_hold_addr; e_fpdata = m_hold_data;
      m_second = 0;
    end else if (wr) begin
      m_cnt = m_cnt + 1'b1;
      if (!flt) begin
        e_intwe = (dst != 0); e_intaddr = dst; e_intdata = lo;
      end else if (dw && src < 2) begin
        e_stall = 1; e_fpwe = 1; e_fpaddr = {dst[4:1], 1'b0}; e_fpdata = lo;
        m_hold_addr = {dst[4:1], 1'b1}; m_hold_data = hi; m_second = 1;
      end else begin
        e_fpwe = 1; e_fpaddr = dst; e_fpdata = lo;
      end
    end
    e_state = m_second;
    exp_q.push_back({e_intwe, e_intaddr, e_intdata, e_fpwe, e_fpaddr, e_fpdata, m_cnt, e_state});
    #1;
    check({tag, "_stall"}, 32'(oStall), 32'(e_stall));
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    {e_intwe, e_intaddr, e_intdata, e_fpwe, e_fpaddr, e_fpdata, m_cnt, e_state} = got;
    check({tag, "_intwe"}, 32'(oIntWe), 32'(e_intwe));
    check({tag, "_fpwe"}, 32'(oFpWe), 32'(e_fpwe));
    if (e_intwe) begin
      check({tag, "_intaddr"}, 32'(oIntAddr), 32'(e_intaddr));
      check({tag, "_intdata"}, oIntData, e_intdata);
    end
    if (e_fpwe) begin
      check({tag, "_fpaddr"}, 32'(oFpAddr), 32'(e_fpaddr));
      check({tag, "_fpdata"}, oFpData, e_fpdata);
    end
    check({tag, "_retired"}, 32'(oRetired), 32'(m_cnt));
    check({tag, "_state"}, 32'(oDbgState), 32'(e_state));
  endtask

  task automatic idle_step(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    iWrite = 0; iFloat = 0; iDW = 0; iWBsrc = 0;
    iALUout1 = 0; iALUout2 = 0; iMemOut1 = 0; iMemOut2 = 0;
    iPcp4 = 0; iIm = 0; iDstReg = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst");
    @(negedge clk);
    rst_n = 1;
    #1 check_all_zero("rst_rel");
  endtask

  initial begin
    apply_reset();

    // integer ALU write
    step("int_alu", 1, 0, 0, 0, 32'h12345678, 0, 0, 0, 0, 0, 5'd9);
    check("int_alu_cnt1", 32'(oRetired), 1);

    // $zero suppression, then link to r31
    step("zero_link", 1, 0, 0, 2, 0, 0, 0, 0, 32'h40, 0, 5'd0);
    step("link_r31", 1, 0, 0, 2, 0, 0, 0, 0, 32'h40, 0, 5'd31);
    check("link_cnt3", 32'(oRetired), 3);

    // DW load held for two cycles
    step("dw_c0", 1, 1, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB1111, 0, 0, 5'd5);
    step("dw_c1", 1, 1, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB1111, 0, 0, 5'd5);
    check("dw_cnt4", 32'(oRetired), 4);
    idle_step("dw_idle");

    // DW flag with an immediate source is a single-word write
    step("dw_imm", 1, 1, 1, 3, 0, 0, 0, 0, 0, 32'h7, 5'd6);
    // DW flag on an integer destination is ignored too
    step("dw_int", 1, 0, 1, 0, 32'hCAFE0001, 32'hDEAD, 0, 0, 0, 0, 5'd7);

    // reset asserted while in SECOND
    step("rdw_c0", 1, 1, 1, 0, 32'h11112222, 32'h33334444, 0, 0, 0, 0, 5'd10);
    iWrite = 0; iFloat = 0; iDW = 0;
    rst_n = 0;
    #1 check_all_zero("rst_mid_dw");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle_step("rst_no_second");
    idle_step("rst_idle2");

    // counter wrap: 17 writes on a 4-bit counter
    for (int i = 0; i < 17; i++)
      step("wrap", 1, 0, 0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
    check("wrap_final", 32'(oRetired), 1);

    // random mix, including DW sequences and idles
    for (int i = 0; i < 40; i++) begin
      if (m_second)
        step("rnd_sec", 1, 1, 1, 2'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
      else
        step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, 5'($urandom_range(0, 31)));
    end
    idle_step("tail");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
